// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM encoding, R/W bit values and a shift helper.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 7;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_REG      = 3'd3,
    ST_ACK_REG  = 3'd4,
    ST_DATA     = 3'd5,
    ST_ACK_DATA = 3'd6,
    ST_IGNORE   = 3'd7
  } slv_state_e;

  // MSB-first serial shift: newest bit enters at the LSB.
  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] sr, input logic b);
    return {sr[BYTE_W-2:0], b};
  endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// SCL/SDA sampling (optional 2-flop synchroniser) with SCL edge and START/STOP detection.
module i2c_bus_sampler #(
  parameter bit SYNC_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic scl_pre, sda_pre;
  logic scl_s_q, scl_s_d, sda_s_q, sda_s_d;
  logic scl_q, scl_q_d, sda_q, sda_q_d;

  if (SYNC_EN) begin : g_sync
    logic scl_meta_q, sda_meta_q;
    // Bus idles high, so synchroniser resets high to avoid false edges.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        scl_meta_q <= 1'b1;
        sda_meta_q <= 1'b1;
      end else begin
        scl_meta_q <= scl_in;
        sda_meta_q <= sda_in;
      end
    end
    assign scl_pre = scl_meta_q;
    assign sda_pre = sda_meta_q;
  end else begin : g_direct
    assign scl_pre = scl_in;
    assign sda_pre = sda_in;
  end

  always_comb begin
    scl_s_d = scl_pre;
    sda_s_d = sda_pre;
    scl_q_d = scl_s_q;
    sda_q_d = sda_s_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s_q <= 1'b1;
      sda_s_q <= 1'b1;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      scl_s_q <= scl_s_d;
      sda_s_q <= sda_s_d;
      scl_q   <= scl_q_d;
      sda_q   <= sda_q_d;
    end
  end

  assign sda_s      = sda_s_q;
  assign scl_rise_c = !scl_q & scl_s_q;
  assign scl_fall_c = scl_q & !scl_s_q;
  assign start_c    = scl_s_q & scl_q & sda_q & !sda_s_q;
  assign stop_c     = scl_s_q & scl_q & !sda_q & sda_s_q;

endmodule

// File: rtl/i2c_slave_receiver.sv
// I2C write-only slave: address match, register pointer + data bytes, ACK drive, write strobe.
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter bit         SYNC_EN  = 1'b0
) (
  input  logic       CLK_200KHZ,
  input  logic       RESET,
  input  logic       I2C_SCL,
  input  logic       I2C_SDA_IN,
  output logic       I2C_SDA_OUT,
  output logic       I2C_SDA_EN,
  output logic [7:0] REG_ADDR_OUT,
  output logic [7:0] DATA_OUT,
  output logic       WR_VALID,
  output logic       BUSY,
  output logic       NACK_FLAG
);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sampler #(.SYNC_EN(SYNC_EN)) u_sampler (
    .clk        (CLK_200KHZ),
    .rst        (RESET),
    .scl_in     (I2C_SCL),
    .sda_in     (I2C_SDA_IN),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  slv_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic [BYTE_W-1:0] reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              sda_en_q, sda_en_d;
  logic              wr_valid_q, wr_valid_d;
  logic              busy_q, busy_d;
  logic              nack_q, nack_d;
  logic [BYTE_W-1:0] rx_byte_c;

  assign rx_byte_c = shift_in(shift_q, sda_s);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    reg_addr_d = reg_addr_q;
    data_d     = data_q;
    sda_en_d   = sda_en_q;
    wr_valid_d = 1'b0;
    nack_d     = nack_q;

    if (stop_c) begin
      state_d   = ST_IDLE;
      sda_en_d  = 1'b0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (start_c) begin
      state_d   = ST_ADDR;
      sda_en_d  = 1'b0;
      bit_cnt_d = '0;
      shift_d   = '0;
      nack_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_REG, ST_DATA: begin
          if (scl_rise_c) begin
            shift_d = rx_byte_c;
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (rx_byte_c[7:1] == DEV_ADDR && rx_byte_c[0] == I2C_WRITE) begin
                  state_d = ST_ACK_ADDR;
                end else begin
                  state_d = ST_IGNORE;
                  nack_d  = 1'b1;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = rx_byte_c;
                state_d = ST_ACK_REG;
              end else begin
                state_d = ST_ACK_DATA;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        // First SCL fall opens the ACK window, the second closes it.
        ST_ACK_ADDR, ST_ACK_REG, ST_ACK_DATA: begin
          if (scl_fall_c) begin
            if (!sda_en_q) begin
              sda_en_d = 1'b1;
              if (state_q == ST_ACK_DATA) begin
                reg_addr_d = ptr_q;
                data_d     = shift_q;
                wr_valid_d = 1'b1;
              end
            end else begin
              sda_en_d = 1'b0;
              if (state_q == ST_ACK_ADDR) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_DATA;
                if (state_q == ST_ACK_DATA) begin
                  ptr_d = ptr_q + BYTE_W'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_200KHZ or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      reg_addr_q <= '0;
      data_q     <= '0;
      sda_en_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      reg_addr_q <= reg_addr_d;
      data_q     <= data_d;
      sda_en_q   <= sda_en_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  assign I2C_SDA_OUT  = 1'b0;
  assign I2C_SDA_EN   = sda_en_q;
  assign REG_ADDR_OUT = reg_addr_q;
  assign DATA_OUT     = data_q;
  assign WR_VALID     = wr_valid_q;
  assign BUSY         = busy_q;
  assign NACK_FLAG    = nack_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: bus-level master model, frame table, write scoreboard.
module tb_i2c_slave_receiver;

  localparam int H = 2;  // clocks per SCL phase

  logic       clk = 1'b0;
  logic       RESET;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       I2C_SDA_OUT, I2C_SDA_EN;
  logic [7:0] REG_ADDR_OUT, DATA_OUT;
  logic       WR_VALID, BUSY, NACK_FLAG;

  always #5 clk = ~clk;

  // Wired-AND open-drain bus: slave pulls low when enabled.
  assign sda_bus = m_sda & ~I2C_SDA_EN;

  i2c_slave_receiver #(.DEV_ADDR(7'h1A), .SYNC_EN(1'b0)) dut (
    .CLK_200KHZ   (clk),
    .RESET        (RESET),
    .I2C_SCL      (m_scl),
    .I2C_SDA_IN   (sda_bus),
    .I2C_SDA_OUT  (I2C_SDA_OUT),
    .I2C_SDA_EN   (I2C_SDA_EN),
    .REG_ADDR_OUT (REG_ADDR_OUT),
    .DATA_OUT     (DATA_OUT),
    .WR_VALID     (WR_VALID),
    .BUSY         (BUSY),
    .NACK_FLAG    (NACK_FLAG)
  );

  typedef struct {
    logic [7:0]  addr_byte;
    logic [7:0]  reg_b;
    int unsigned n_data;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        exp_ack;
    logic        exp_nack;
  } frame_t;

  typedef struct {
    logic [7:0] ra;
    logic [7:0] rd;
  } wr_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned en_rises = 0;
  int unsigned n_writes = 0;
  wr_t         exp_q[$];
  logic [7:0]  last_reg = 8'h00;
  logic [7:0]  last_data = 8'h00;
  logic        en_prev = 1'b0;
  logic        wr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0; tick(1);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(H);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    tick(H);
    m_scl = 1'b1; tick(H);
    m_scl = 1'b0; tick(1);
  endtask

  task automatic read_ack(output logic ack);
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(1);
    ack = (sda_bus == 1'b0);
    tick(H - 1);
    m_scl = 1'b0; tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_ack(ack);
  endtask

  task automatic push_wr(input logic [7:0] ra, input logic [7:0] rd);
    wr_t w;
    w.ra = ra;
    w.rd = rd;
    exp_q.push_back(w);
    last_reg  = ra;
    last_data = rd;
  endtask

  task automatic run_frame(input string tag, input frame_t f);
    logic        ack;
    int unsigned en0, wr0;
    logic [7:0]  ra;
    en0 = en_rises;
    wr0 = n_writes;
    if (f.exp_ack) begin
      ra = f.reg_b;
      if (f.n_data >= 1) push_wr(ra, f.d0);
      ra = ra + 8'd1;
      if (f.n_data >= 2) push_wr(ra, f.d1);
    end
    i2c_start();
    send_byte(f.addr_byte, ack);
    chk({tag, " addr_ack"}, 32'(ack), 32'(f.exp_ack));
    chk({tag, " busy_mid"}, 32'(BUSY), 32'd1);
    send_byte(f.reg_b, ack);
    chk({tag, " reg_ack"}, 32'(ack), 32'(f.exp_ack));
    if (f.n_data >= 1) begin
      send_byte(f.d0, ack);
      chk({tag, " d0_ack"}, 32'(ack), 32'(f.exp_ack));
    end
    if (f.n_data >= 2) begin
      send_byte(f.d1, ack);
      chk({tag, " d1_ack"}, 32'(ack), 32'(f.exp_ack));
    end
    i2c_stop();
    chk({tag, " busy_after_stop"}, 32'(BUSY), 32'd0);
    chk({tag, " nack_flag"}, 32'(NACK_FLAG), 32'(f.exp_nack));
    chk({tag, " en_windows"}, en_rises - en0, f.exp_ack ? 32'(2 + f.n_data) : 32'd0);
    chk({tag, " writes"}, n_writes - wr0, f.exp_ack ? 32'(f.n_data) : 32'd0);
    chk({tag, " reg_out_hold"}, 32'(REG_ADDR_OUT), 32'(last_reg));
    chk({tag, " data_out_hold"}, 32'(DATA_OUT), 32'(last_data));
    chk({tag, " sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every WR_VALID pops and compares one expected write.
  always @(negedge clk) begin
    if (RESET) begin
      en_prev = 1'b0;
      wr_prev = 1'b0;
    end else begin
      if (I2C_SDA_EN && !en_prev) en_rises++;
      if (WR_VALID) begin
        n_writes++;
        if (wr_prev) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_consecutive: WR_VALID high two clocks, expected single pulse (t=%0t)", $time);
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_unexpected: got reg %0h data %0h, expected no write (t=%0t)",
                   REG_ADDR_OUT, DATA_OUT, $time);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_reg", 32'(REG_ADDR_OUT), 32'(w.ra));
          chk("wr_data", 32'(DATA_OUT), 32'(w.rd));
        end
      end
      en_prev = I2C_SDA_EN;
      wr_prev = WR_VALID;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_t rows[6];
    logic   ack;
    int unsigned wr0;

    rows[0] = '{addr_byte: 8'h34, reg_b: 8'h0F, n_data: 1, d0: 8'hA5, d1: 8'h00, exp_ack: 1'b1, exp_nack: 1'b0};
    rows[1] = '{addr_byte: 8'h36, reg_b: 8'h0F, n_data: 1, d0: 8'hA5, d1: 8'h00, exp_ack: 1'b0, exp_nack: 1'b1};
    rows[2] = '{addr_byte: 8'h35, reg_b: 8'h0F, n_data: 1, d0: 8'hA5, d1: 8'h00, exp_ack: 1'b0, exp_nack: 1'b1};
    rows[3] = '{addr_byte: 8'h34, reg_b: 8'hFF, n_data: 2, d0: 8'h11, d1: 8'h22, exp_ack: 1'b1, exp_nack: 1'b0};
    rows[4] = '{addr_byte: 8'h34, reg_b: 8'h40, n_data: 0, d0: 8'h00, d1: 8'h00, exp_ack: 1'b1, exp_nack: 1'b0};
    rows[5] = '{addr_byte: 8'h00, reg_b: 8'h12, n_data: 2, d0: 8'h33, d1: 8'h44, exp_ack: 1'b0, exp_nack: 1'b1};

    RESET = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(3);
    chk("rst sda_en", 32'(I2C_SDA_EN), 32'd0);
    chk("rst sda_out", 32'(I2C_SDA_OUT), 32'd0);
    chk("rst reg_addr", 32'(REG_ADDR_OUT), 32'd0);
    chk("rst data", 32'(DATA_OUT), 32'd0);
    chk("rst wr_valid", 32'(WR_VALID), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst nack", 32'(NACK_FLAG), 32'd0);
    RESET = 1'b0;
    tick(3);
    chk("idle busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < 6; i++) run_frame($sformatf("row%0d", i), rows[i]);

    // Repeated START after 4 data bits: partial byte dropped, new frame written.
    wr0 = n_writes;
    i2c_start();
    send_byte(8'h34, ack);
    chk("rs addr_ack", 32'(ack), 32'd1);
    send_byte(8'h05, ack);
    chk("rs reg_ack", 32'(ack), 32'd1);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
    push_wr(8'h02, 8'h7E);
    i2c_start();
    chk("rs busy_after_rstart", 32'(BUSY), 32'd1);
    send_byte(8'h34, ack);
    chk("rs addr2_ack", 32'(ack), 32'd1);
    send_byte(8'h02, ack);
    chk("rs reg2_ack", 32'(ack), 32'd1);
    send_byte(8'h7E, ack);
    chk("rs data2_ack", 32'(ack), 32'd1);
    i2c_stop();
    chk("rs writes", n_writes - wr0, 32'd1);
    chk("rs sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rs reg_out", 32'(REG_ADDR_OUT), 32'h02);
    chk("rs data_out", 32'(DATA_OUT), 32'h7E);
    chk("rs busy_after_stop", 32'(BUSY), 32'd0);

    // Asynchronous reset while the data ACK is being driven.
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h10, ack);
    push_wr(8'h10, 8'h99);
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h99 >> i));
    tick(1);
    chk("ar en_before_reset", 32'(I2C_SDA_EN), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("ar en_async", 32'(I2C_SDA_EN), 32'd0);
    chk("ar reg_addr", 32'(REG_ADDR_OUT), 32'd0);
    chk("ar data", 32'(DATA_OUT), 32'd0);
    chk("ar wr_valid", 32'(WR_VALID), 32'd0);
    chk("ar busy", 32'(BUSY), 32'd0);
    chk("ar nack", 32'(NACK_FLAG), 32'd0);
    chk("ar sb_empty", 32'(exp_q.size()), 32'd0);
    last_reg  = 8'h00;
    last_data = 8'h00;
    tick(2);
    RESET = 1'b0;
    tick(2);
    i2c_stop();
    run_frame("post_reset", '{addr_byte: 8'h34, reg_b: 8'h21, n_data: 1, d0: 8'h5A, d1: 8'h00,
                              exp_ack: 1'b1, exp_nack: 1'b0});

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
